// File: rtl/event_tagger_pkg.sv
// Shared constants for the event tagger: register map defaults, CTRL bit
// positions and record field offsets.
package event_tagger_pkg;

    localparam int CTRL_ADDR_DEF = 1;
    localparam int MASK_ADDR_DEF = 2;

    localparam int CAPTURE_BIT   = 0;
    localparam int COUNTER_BIT   = 1;
    localparam int RESET_CNT_BIT = 2;
    localparam int CTRL_W        = 3;

    localparam int LOST_W = 16;

    // Record layout, LSB first: ts, delta, strobe, lost, wrap
    function automatic int rec_w(input int n, input int ts_w);
        return ts_w + 2 * n + 2;
    endfunction

    function automatic int rec_delta_lsb(input int ts_w);
        return ts_w;
    endfunction

    function automatic int rec_strobe_lsb(input int n, input int ts_w);
        return ts_w + n;
    endfunction

    function automatic int rec_lost_bit(input int n, input int ts_w);
        return ts_w + 2 * n;
    endfunction

    function automatic int rec_wrap_bit(input int n, input int ts_w);
        return ts_w + 2 * n + 1;
    endfunction

endpackage

// File: rtl/tagger_fifo.sv
// First-word-fall-through record FIFO; the head word is presented on o_data
// whenever the FIFO is non-empty and reads as zero when empty.
module tagger_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr,
    input  logic [W-1:0]             i_data,
    input  logic                     i_rd,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_level = r_cnt;
    assign o_data  = o_empty ? '0 : r_mem[r_rp];

    assign w_pop  = i_rd && !o_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign w_push = i_wr && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/event_tagger_n.sv
// N-channel strobe/delta event tagger with timestamping and record FIFO.
// Define EVENT_TAGGER_WRAP_RECORD_EN to emit stand-alone counter-wrap records.
module event_tagger_n
    import event_tagger_pkg::*;
#(
    parameter int N         = 4,
    parameter int TS_W      = 36,
    parameter int DEPTH     = 16,
    parameter int CTRL_ADDR = CTRL_ADDR_DEF,
    parameter int MASK_ADDR = MASK_ADDR_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N-1:0]             strobe_in,
    input  logic [N-1:0]             delta_in,
    input  logic [7:0]               reg_addr,
    input  logic [7:0]               reg_data,
    input  logic                     reg_wr,
    output logic                     operate,
    output logic                     data_rdy,
    input  logic                     data_ack,
    output logic [TS_W+2*N+1:0]      data,
    output logic [LOST_W-1:0]        lost_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int REC_W = rec_w(N, TS_W);

    logic [CTRL_W-1:0] r_ctrl;
    logic [N-1:0]      r_mask;
    logic [N-1:0]      r_s1, r_s2, r_s3;
    logic [N-1:0]      r_d1, r_d2, r_d3;
    logic [TS_W-1:0]   r_ts;
    logic              r_wrap;
    logic              r_pend_lost;
    logic [LOST_W-1:0] r_lost;

    logic [N-1:0]      w_strobe_pulse;
    logic [N-1:0]      w_delta_chg;
    logic              w_evt;
    logic              w_gen;
    logic              w_rd;
    logic              w_wr_ok;
    logic              w_full;
    logic              w_empty;
    logic [REC_W-1:0]  w_rec;
    logic              w_unused_reg;

    assign w_unused_reg = ^reg_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl <= '0;
            r_mask <= '1;
        end else if (reg_wr) begin
            if (reg_addr == 8'(CTRL_ADDR)) r_ctrl <= reg_data[CTRL_W-1:0];
            if (reg_addr == 8'(MASK_ADDR)) r_mask <= reg_data[N-1:0];
        end
    end

    assign operate = r_ctrl[CAPTURE_BIT];

    // Two sync flops plus one history flop per channel for edge/change detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
            r_d3 <= '0;
        end else begin
            r_s1 <= strobe_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_d1 <= delta_in;
            r_d2 <= r_d1;
            r_d3 <= r_d2;
        end
    end

    assign w_strobe_pulse = r_s2 & ~r_s3 & r_mask;
    assign w_delta_chg    = (r_d2 ^ r_d3) & r_mask;

    // r_wrap is high exactly in the cycle where ts has just rolled over to 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts   <= '0;
            r_wrap <= 1'b0;
        end else if (r_ctrl[RESET_CNT_BIT]) begin
            r_ts   <= '0;
            r_wrap <= 1'b0;
        end else if (r_ctrl[COUNTER_BIT]) begin
            r_ts   <= r_ts + TS_W'(1);
            r_wrap <= &r_ts;
        end else begin
            r_wrap <= 1'b0;
        end
    end

`ifdef EVENT_TAGGER_WRAP_RECORD_EN
    assign w_evt = (|w_strobe_pulse) || (|w_delta_chg) || r_wrap;
`else
    assign w_evt = (|w_strobe_pulse) || (|w_delta_chg);
`endif

    assign w_gen   = r_ctrl[CAPTURE_BIT] && w_evt;
    assign w_rec   = {r_wrap, r_pend_lost, w_strobe_pulse, r_d2 & r_mask, r_ts};
    assign w_rd    = data_rdy && data_ack;
    assign w_wr_ok = w_gen && (!w_full || w_rd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_lost <= 1'b0;
            r_lost      <= '0;
        end else if (w_wr_ok) begin
            r_pend_lost <= 1'b0;
        end else if (w_gen) begin
            r_pend_lost <= 1'b1;
            if (r_lost != '1) r_lost <= r_lost + LOST_W'(1);
        end
    end

    assign lost_count = r_lost;
    assign data_rdy   = !w_empty;

    tagger_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_wr    (w_wr_ok),
        .i_data  (w_rec),
        .i_rd    (w_rd),
        .o_data  (data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

endmodule

// File: tb/tb_event_tagger_n.sv
// Scoreboard bench for event_tagger_n (N=4, TS_W=8, DEPTH=16).
module tb_event_tagger_n;
    localparam int N     = 4;
    localparam int TS_W  = 8;
    localparam int DEPTH = 16;
    localparam int REC_W = TS_W + 2 * N + 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [N-1:0]     strobe_in = '0;
    logic [N-1:0]     delta_in = '0;
    logic [7:0]       reg_addr = '0;
    logic [7:0]       reg_data = '0;
    logic             reg_wr = 1'b0;
    logic             operate;
    logic             data_rdy;
    logic             data_ack = 1'b0;
    logic [REC_W-1:0] data;
    logic [15:0]      lost_count;
    logic [4:0]       fifo_level;

    always #5 clk = ~clk;

    event_tagger_n #(
        .N(N), .TS_W(TS_W), .DEPTH(DEPTH), .CTRL_ADDR(1), .MASK_ADDR(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .strobe_in(strobe_in), .delta_in(delta_in),
        .reg_addr(reg_addr), .reg_data(reg_data), .reg_wr(reg_wr),
        .operate(operate), .data_rdy(data_rdy), .data_ack(data_ack), .data(data),
        .lost_count(lost_count), .fifo_level(fifo_level)
    );

    logic [REC_W-1:0] q[$];
    int total = 0;
    int bad = 0;

    // Reference view of CTRL/MASK and the timestamp counter
    logic [2:0]      m_ctrl;
    logic [N-1:0]    m_mask;
    logic [TS_W-1:0] m_ts;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ctrl <= '0;
            m_mask <= '1;
            m_ts   <= '0;
        end else begin
            if (m_ctrl[2])      m_ts <= '0;
            else if (m_ctrl[1]) m_ts <= m_ts + 8'd1;
            if (reg_wr && reg_addr == 8'd1) m_ctrl <= reg_data[2:0];
            if (reg_wr && reg_addr == 8'd2) m_mask <= reg_data[N-1:0];
        end
    end

    always @(negedge clk) begin
        if (reset_n && data_rdy && data_ack) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL rec_unexpected: got %h, expected no record", data);
            end else begin
                logic [REC_W-1:0] e;
                e = q.pop_front();
                if (data !== e) begin
                    bad++;
                    $display("FAIL rec: got %h, expected %h", data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        reg_addr = a;
        reg_data = d;
        reg_wr   = 1'b1;
        tick();
        reg_wr   = 1'b0;
    endtask

    // Expected record for an event whose input changes now (record 2 edges later)
    function automatic logic [REC_W-1:0] mk(input logic [N-1:0] s, input logic [N-1:0] dl,
                                             input logic lost);
        logic [TS_W-1:0] t;
        logic            w;
        t = m_ctrl[2] ? '0 : (m_ctrl[1] ? m_ts + 8'd2 : m_ts);
        w = m_ctrl[1] && !m_ctrl[2] && (t == '0);
        return {w, lost, s & m_mask, dl & m_mask, t};
    endfunction

    task automatic strobe(input int ch, input bit push, input logic lost);
        logic [N-1:0] s;
        s = '0;
        s[ch] = 1'b1;
        strobe_in[ch] = 1'b1;
        if (push) q.push_back(mk(s, delta_in, lost));
        tick();
        strobe_in[ch] = 1'b0;
        tick();
    endtask

    initial begin
        ticks(3);
        chk("reset_rdy", 32'(data_rdy), 0);
        chk("reset_level", 32'(fifo_level), 0);
        chk("reset_lost", 32'(lost_count), 0);
        chk("reset_data", 32'(data), 0);
        chk("reset_operate", 32'(operate), 0);
        reset_n = 1'b1;
        data_ack = 1'b1;
        tick();

        // Single strobe held 3 cycles, counter from 0: one record at ts=2
        wr(8'd1, 8'h03);
        chk("operate_on", 32'(operate), 1);
        strobe_in[2] = 1'b1;
        q.push_back({1'b0, 1'b0, 4'b0100, 4'b0000, 8'd2});
        ticks(3);
        strobe_in[2] = 1'b0;
        ticks(8);
        chk("single_drained", 32'(q.size()), 0);

        // Masked strobe gives nothing; delta edges give records both ways
        wr(8'd2, 8'h0E);
        strobe(0, 0, 1'b0);
        ticks(5);
        delta_in[1] = 1'b1;
        q.push_back(mk('0, 4'b0010, 1'b0));
        ticks(6);
        delta_in[1] = 1'b0;
        q.push_back(mk('0, 4'b0000, 1'b0));
        ticks(6);
        wr(8'd2, 8'hFF);
        chk("mask_drained", 32'(q.size()), 0);

        // Overflow with counter frozen: 20 events into a 16-deep FIFO
        wr(8'd1, 8'h01);
        data_ack = 1'b0;
        for (int i = 0; i < 20; i++) strobe(3, i < 16, 1'b0);
        ticks(4);
        chk("ovf_level", 32'(fifo_level), 16);
        chk("ovf_lost", 32'(lost_count), 4);
        chk("ovf_rdy", 32'(data_rdy), 1);
        data_ack = 1'b1;
        ticks(20);
        chk("ovf_drained_level", 32'(fifo_level), 0);
        strobe(1, 1, 1'b1);
        strobe(1, 1, 1'b0);
        ticks(6);
        chk("ovf_lost_hold", 32'(lost_count), 4);

        // Counter held in clear, then released: ts restarts from 0
        wr(8'd1, 8'h07);
        ticks(10);
        wr(8'd1, 8'h03);
        strobe_in[1] = 1'b1;
        q.push_back({1'b0, 1'b0, 4'b0010, 4'b0000, 8'd2});
        tick();
        strobe_in[1] = 1'b0;
        ticks(8);
        chk("hold_drained", 32'(q.size()), 0);

        // Idle with counter running across two 8-bit wraps
        for (int i = 0; i < 600; i++) begin
            tick();
`ifdef EVENT_TAGGER_WRAP_RECORD_EN
            if (m_ts == '0) q.push_back({1'b1, 1'b0, 4'b0000, 4'b0000, 8'd0});
`endif
        end
        ticks(4);
        chk("wrap_drained", 32'(q.size()), 0);

        // Mid-stream reset with 5 records buffered
        wr(8'd1, 8'h01);
        data_ack = 1'b0;
        for (int i = 0; i < 5; i++) strobe(2, 0, 1'b0);
        ticks(4);
        chk("pre_reset_level", 32'(fifo_level), 5);
        chk("pre_reset_lost", 32'(lost_count), 4);
        reset_n = 1'b0;
        #1;
        chk("async_rdy", 32'(data_rdy), 0);
        chk("async_level", 32'(fifo_level), 0);
        chk("async_lost", 32'(lost_count), 0);
        chk("async_operate", 32'(operate), 0);
        ticks(2);
        reset_n = 1'b1;
        data_ack = 1'b1;
        tick();
        // CTRL=0 after reset: capture off
        strobe(3, 0, 1'b0);
        ticks(5);
        chk("ctrl_default_level", 32'(fifo_level), 0);
        // MASK=FF after reset: channel 0 enabled
        wr(8'd1, 8'h03);
        strobe(0, 1, 1'b0);
        ticks(8);
        chk("final_drained", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
